// File: rtl/cordic_vectoring.sv
// rtl/cordic_vectoring.sv - pipelined vectoring-mode CORDIC, (x,y) to magnitude/phase
//
// Purpose:
//   Converts a signed (x,y) vector into gain-compensated magnitude and phase.
//   Phase uses 20-bit turn encoding (2^20 = 360 deg, 0x40000 = +90 deg).
//   Stage 0 pre-rotates into the right half-plane and performs iteration 0;
//   stages 1..STAGES-1 perform the remaining iterations; one output register
//   applies the gain correction and saturation. Global stall on backpressure.
//
// Ports:
//   clk        in   1           system clock
//   rst        in   1           synchronous active-high reset
//   in_valid   in   1           x_in/y_in valid
//   in_ready   out  1           sample accepted this cycle when in_valid high
//   x_in       in   DATA_WIDTH  signed x (I)
//   y_in       in   DATA_WIDTH  signed y (Q)
//   out_valid  out  1           mag_out/phase_out valid
//   out_ready  in   1           downstream accepts output
//   mag_out    out  DATA_WIDTH  unsigned magnitude
//   phase_out  out  20          signed phase in turn encoding
//
// Configuration macro:
//   CORDIC_VEC_ROUND_EN  rounding shifts in iterations and gain step.

module cordic_vectoring #(
    parameter int DATA_WIDTH = 12,
    parameter int STAGES     = 10
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic signed [DATA_WIDTH-1:0] x_in,
    input  logic signed [DATA_WIDTH-1:0] y_in,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic        [DATA_WIDTH-1:0] mag_out,
    output logic        [19:0]           phase_out
);

    // Two guard bits: one for negating -2^(DW-1), one for the CORDIC gain
    // growth on a full-scale diagonal (1.647 * sqrt2 < 4).
    localparam int IW = DATA_WIDTH + 2;
    localparam int PW = IW + 12;

    function automatic logic [19:0] f_atan(input int i);
        case (i)
            0:       f_atan = 20'd131072;
            1:       f_atan = 20'd77376;
            2:       f_atan = 20'd40884;
            3:       f_atan = 20'd20753;
            4:       f_atan = 20'd10417;
            5:       f_atan = 20'd5213;
            6:       f_atan = 20'd2607;
            7:       f_atan = 20'd1304;
            8:       f_atan = 20'd652;
            9:       f_atan = 20'd326;
            10:      f_atan = 20'd163;
            11:      f_atan = 20'd81;
            12:      f_atan = 20'd41;
            13:      f_atan = 20'd20;
            14:      f_atan = 20'd10;
            15:      f_atan = 20'd5;
            default: f_atan = 20'd0;
        endcase
    endfunction

    function automatic logic signed [IW-1:0] f_shr(input logic signed [IW-1:0] v,
                                                   input int sh);
        logic signed [IW-1:0] t;
        t = v;
`ifdef CORDIC_VEC_ROUND_EN
        if (sh > 0) begin
            t = v + (IW'(1) << (sh - 1));
        end
`endif
        f_shr = t >>> sh;
    endfunction

    logic signed [IW-1:0] r_x [STAGES];
    logic signed [IW-1:0] r_y [STAGES];
    logic        [19:0]   r_z [STAGES];
    logic [STAGES-1:0]    r_v;
    logic [STAGES-1:0]    r_zero;

    logic                  r_ovalid;
    logic [DATA_WIDTH-1:0] r_mag;
    logic [19:0]           r_phase;

    logic                  w_adv;
    logic signed [IW-1:0]  w_xi;
    logic signed [IW-1:0]  w_yi;
    logic signed [IW-1:0]  w_xs  [STAGES];
    logic signed [IW-1:0]  w_ys  [STAGES];
    logic        [19:0]    w_zs  [STAGES];
    logic signed [IW-1:0]  w_xsh [STAGES];
    logic signed [IW-1:0]  w_ysh [STAGES];
    logic signed [IW-1:0]  w_x_nxt [STAGES];
    logic signed [IW-1:0]  w_y_nxt [STAGES];
    logic        [19:0]    w_z_nxt [STAGES];
    logic signed [PW-1:0]  w_prod;
    logic signed [PW-1:0]  w_mag_full;
    logic [DATA_WIDTH-1:0] w_mag_sat;
    logic                  w_in_zero;

    assign w_adv     = out_ready | ~r_ovalid;
    assign in_ready  = w_adv;
    assign out_valid = r_ovalid;
    assign mag_out   = r_mag;
    assign phase_out = r_phase;

    assign w_xi      = IW'(x_in);
    assign w_yi      = IW'(y_in);
    assign w_in_zero = (x_in == '0) && (y_in == '0);

    always_comb begin
        // Pre-rotation by 180 deg folds the left half-plane into the right one.
        if (x_in[DATA_WIDTH-1]) begin
            w_xs[0] = -w_xi;
            w_ys[0] = -w_yi;
            w_zs[0] = 20'h80000;
        end else begin
            w_xs[0] = w_xi;
            w_ys[0] = w_yi;
            w_zs[0] = 20'h00000;
        end
        for (int s = 1; s < STAGES; s++) begin
            w_xs[s] = r_x[s-1];
            w_ys[s] = r_y[s-1];
            w_zs[s] = r_z[s-1];
        end
        for (int s = 0; s < STAGES; s++) begin
            w_xsh[s] = f_shr(w_xs[s], s);
            w_ysh[s] = f_shr(w_ys[s], s);
            if (!w_ys[s][IW-1]) begin
                w_x_nxt[s] = w_xs[s] + w_ysh[s];
                w_y_nxt[s] = w_ys[s] - w_xsh[s];
                w_z_nxt[s] = w_zs[s] + f_atan(s);
            end else begin
                w_x_nxt[s] = w_xs[s] - w_ysh[s];
                w_y_nxt[s] = w_ys[s] + w_xsh[s];
                w_z_nxt[s] = w_zs[s] - f_atan(s);
            end
        end
    end

    // Gain compensation: 1242/2048 approximates 1/1.647.
    always_comb begin
        w_prod = PW'(r_x[STAGES-1]) * PW'(1242);
`ifdef CORDIC_VEC_ROUND_EN
        w_mag_full = (w_prod + PW'(1024)) >>> 11;
`else
        w_mag_full = w_prod >>> 11;
`endif
        if (w_mag_full < 0) begin
            w_mag_sat = '0;
        end else if (w_mag_full > PW'((1 << DATA_WIDTH) - 1)) begin
            w_mag_sat = '1;
        end else begin
            w_mag_sat = w_mag_full[DATA_WIDTH-1:0];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int s = 0; s < STAGES; s++) begin
                r_x[s] <= '0;
                r_y[s] <= '0;
                r_z[s] <= '0;
            end
            r_v      <= '0;
            r_zero   <= '0;
            r_ovalid <= 1'b0;
            r_mag    <= '0;
            r_phase  <= '0;
        end else if (w_adv) begin
            r_v[0]    <= in_valid;
            r_zero[0] <= w_in_zero;
            for (int s = 1; s < STAGES; s++) begin
                r_v[s]    <= r_v[s-1];
                r_zero[s] <= r_zero[s-1];
            end
            for (int s = 0; s < STAGES; s++) begin
                r_x[s] <= w_x_nxt[s];
                r_y[s] <= w_y_nxt[s];
                r_z[s] <= w_z_nxt[s];
            end
            r_ovalid <= r_v[STAGES-1];
            // A zero vector has no defined angle; force a clean 0/0 result.
            if (r_zero[STAGES-1]) begin
                r_mag   <= '0;
                r_phase <= '0;
            end else begin
                r_mag   <= w_mag_sat;
                r_phase <= r_z[STAGES-1];
            end
        end
    end

endmodule

// File: tb/tb_cordic_vectoring.sv
// tb/tb_cordic_vectoring.sv - scoreboard bench for cordic_vectoring
module tb_cordic_vectoring;

    localparam int    DW = 12;
    localparam real   PI = 3.14159265358979;
    // CORDIC gain for 10 iterations times the 1242/2048 correction factor.
    localparam real   GC = 1.6467602581 * 1242.0 / 2048.0;

    logic                 clk = 1'b0;
    logic                 rst;
    logic                 in_valid;
    logic                 in_ready;
    logic signed [DW-1:0] x_in;
    logic signed [DW-1:0] y_in;
    logic                 out_valid;
    logic                 out_ready;
    logic        [DW-1:0] mag_out;
    logic        [19:0]   phase_out;

    cordic_vectoring #(.DATA_WIDTH(DW), .STAGES(10)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .x_in      (x_in),
        .y_in      (y_in),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .mag_out   (mag_out),
        .phase_out (phase_out)
    );

    always #5 clk = ~clk;

    typedef struct {
        int mag;
        int ph;
        int mtol;
        int ptol;
        int id;
    } exp_t;

    exp_t sb_q[$];
    int   checks   = 0;
    int   failures = 0;
    bit   rand_rdy = 1'b0;

    task automatic check(input string name, input bit ok, input int act, input int req);
        checks++;
        if (!ok) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d", name, act, req);
        end
    endtask

    // Monitor: pops the scoreboard on every output transfer and checks that a
    // stalled output stays put until it is taken.
    exp_t           m_e;
    int             m_dm;
    int             m_dp;
    bit             prev_stall = 1'b0;
    logic [DW-1:0]  prev_mag;
    logic [19:0]    prev_ph;

    always @(negedge clk) begin
        if (rst) begin
            prev_stall = 1'b0;
        end else begin
            if (prev_stall) begin
                check("stall_valid", out_valid == 1'b1, int'(out_valid), 1);
                check("stall_mag", mag_out == prev_mag, int'(mag_out), int'(prev_mag));
                check("stall_phase", phase_out == prev_ph, int'(phase_out), int'(prev_ph));
            end
            if (out_valid && out_ready) begin
                if (sb_q.size() == 0) begin
                    check("unexpected_output", 1'b0, int'(mag_out), -1);
                end else begin
                    m_e  = sb_q.pop_front();
                    m_dm = int'(mag_out) - m_e.mag;
                    if (m_dm < 0) m_dm = -m_dm;
                    m_dp = (int'(phase_out) - m_e.ph) & 32'hFFFFF;
                    if (m_dp >= 524288) m_dp = m_dp - 1048576;
                    if (m_dp < 0) m_dp = -m_dp;
                    check($sformatf("mag[%0d]", m_e.id), m_dm <= m_e.mtol, int'(mag_out), m_e.mag);
                    check($sformatf("phase[%0d]", m_e.id), m_dp <= m_e.ptol, int'(phase_out), m_e.ph);
                end
            end
            prev_stall = out_valid && !out_ready;
            prev_mag   = mag_out;
            prev_ph    = phase_out;
        end
    end

    initial begin
        out_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            out_ready = rand_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    end

    task automatic send(input int x, input int y, input int em, input int ep,
                        input int mt, input int pt, input int id);
        exp_t e;
        x_in     = DW'(x);
        y_in     = DW'(y);
        in_valid = 1'b1;
        for (int w = 0; w < 200; w++) begin
            @(negedge clk);
            if (in_ready) begin
                e.mag  = em;
                e.ph   = ep & 32'hFFFFF;
                e.mtol = mt;
                e.ptol = pt;
                e.id   = id;
                sb_q.push_back(e);
                @(posedge clk);
                #1;
                in_valid = 1'b0;
                return;
            end
            @(posedge clk);
            #1;
        end
        check("send_timeout", 1'b0, 0, 1);
        in_valid = 1'b0;
    endtask

    task automatic wait_drain();
        for (int w = 0; w < 3000; w++) begin
            if (sb_q.size() == 0) break;
            @(posedge clk);
            #1;
        end
        check("drain", sb_q.size() == 0, sb_q.size(), 0);
    endtask

    task automatic send_angle(input int k, input int id);
        real a, xr, yr, ph;
        int  x, y, ep, em;
        a  = real'(k) * PI / 180.0;
        xr = 2000.0 * $cos(a);
        yr = 2000.0 * $sin(a);
        x  = $rtoi(xr >= 0.0 ? xr + 0.5 : xr - 0.5);
        y  = $rtoi(yr >= 0.0 ? yr + 0.5 : yr - 0.5);
        ph = $atan2(real'(y), real'(x)) / (2.0 * PI) * 1048576.0;
        ep = $rtoi(ph >= 0.0 ? ph + 0.5 : ph - 0.5);
        em = $rtoi($sqrt(real'(x * x + y * y)) * GC + 0.5);
        // Last-iteration residual (~326 counts) plus truncation drift.
        send(x, y, em, ep, 4, 800, id);
    endtask

    int n;

    initial begin
        rst      = 1'b1;
        in_valid = 1'b0;
        x_in     = '0;
        y_in     = '0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;

        @(negedge clk);
        check("reset_out_valid", out_valid == 1'b0, int'(out_valid), 0);
        check("reset_in_ready", in_ready == 1'b1, int'(in_ready), 1);
        check("reset_mag", mag_out == '0, int'(mag_out), 0);
        check("reset_phase", phase_out == '0, int'(phase_out), 0);
        @(posedge clk);
        #1;

        // Expected magnitudes: radius * 1.64676 * 1242/2048.
        send(1000, 0, 999, 0, 3, 400, 1);
        n = 1;
        while (n < 40) begin
            @(negedge clk);
            if (out_valid) break;
            @(posedge clk);
            n++;
        end
        check("latency", n == 11, n, 11);
        wait_drain();

        send(0, 1000, 999, 262144, 3, 400, 2);
        send(-1000, 0, 999, 524288, 3, 400, 3);
        send(-2048, -2048, 2892, 655360, 3, 400, 4);
        send(0, 0, 0, 0, 0, 0, 5);
        wait_drain();

        rand_rdy = 1'b1;
        for (int k = 0; k < 360; k++) begin
            send_angle(k, 100 + k);
        end
        wait_drain();

        for (int k = 0; k < 6; k++) begin
            send_angle(k * 50, 1000 + k);
        end
        rst      = 1'b1;
        sb_q.delete();
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check("midreset_out_valid", out_valid == 1'b0, int'(out_valid), 0);
        check("midreset_in_ready", in_ready == 1'b1, int'(in_ready), 1);
        @(posedge clk);
        #1;

        rand_rdy = 1'b0;
        send(0, 1000, 999, 262144, 3, 400, 2000);
        send(0, 0, 0, 0, 0, 0, 2001);
        wait_drain();
        repeat (20) @(posedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

endmodule
